alu_op_issuer: RTL and testbench
================================

// Module: alu_op_issuer
// PURPOSE
//  Initiator side of the sync_arith_unit ALU port interface. Accepts (op, A, B) commands over a
//  valid/ready channel and drives registered operands onto the ALU's i_op/i_arg_A/i_arg_B. Waits
//  the ALU's fixed latency, captures o_result/o_status and returns them on a valid/ready response
//  channel. Sits between a command source (testbench, host register file) and one ALU instance.
// PARAMETERS
//  N        2        opcode width; matches the ALU's N
//  M        4        operand/result width; matches the ALU's M
//  LAT      1        ALU register latency in clocks (>=1)
//  OP_MASK  4'b1010  bit k=1 -> opcode k is supported (default: COMP=01, CONV=11)
// PORTS
//  i_clk         in   1    clock, rising edge
//  i_reset       in   1    asynchronous, active-low reset
//  i_cmd_valid   in   1    command valid
//  o_cmd_ready   out  1    command ready
//  i_cmd_op      in   N    command opcode
//  i_cmd_a       in   M    operand A
//  i_cmd_b       in   M    operand B
//  o_alu_op      out  N    to ALU i_op (registered)
//  o_alu_a       out  M    to ALU i_arg_A (registered)
//  o_alu_b       out  M    to ALU i_arg_B (registered)
//  i_alu_result  in   M    from ALU o_result
//  i_alu_status  in   4    from ALU o_status
//  o_rsp_valid   out  1    response valid
//  i_rsp_ready   in   1    response ready
//  o_rsp_op      out  N    opcode of returned command
//  o_rsp_result  out  M    captured result
//  o_rsp_status  out  4    [3]=unsupported-op flag, [2:0]=captured i_alu_status[2:0]
//  o_err_count   out  8    saturating count of unsupported commands
// BEHAVIOUR
//  - Reset (i_reset=0, async): state IDLE; o_cmd_ready=0 while asserted, 1 from first edge after release.
//    All other outputs are 0 and any in-flight command is dropped with no response.
//  - FSM IDLE -> WAIT -> HOLD -> IDLE; o_cmd_ready=1 in IDLE, and in HOLD only when i_rsp_ready=1.
//  - Accept on edge E0 with i_cmd_valid & o_cmd_ready. i_cmd_* is latched at E0.
//  - Supported op: o_alu_* take the new values at E0 and stay stable until the next accept.
//    The latency counter loads LAT, goes to WAIT and decrements each edge.
//    i_alu_result/status are sampled at edge E(LAT+1) (default E2); o_rsp_valid=1 after that edge.
//  - Unsupported op (OP_MASK[op]=0): o_alu_* are not updated and there is no WAIT.
//    Go straight to HOLD at E0 with result=0, status=4'b1000; o_err_count++ (saturates at 255).
//  - HOLD: o_rsp_* are held stable while i_rsp_ready=0. The response handshake on edge H returns to
//    IDLE, unless a command is accepted on the same edge H; then go straight to WAIT/HOLD for it.
//  - Peak throughput: one supported command per LAT+2 clocks; one unsupported command per clock.
//  - i_cmd_* are ignored when o_cmd_ready=0; the ALU result is ignored outside the capture edge.
//  - Widths: result/status are passed through unmodified; no sign handling in this block.
// TESTING
//  T1 COMP: op=01, A=4'b0011, B=4'b0101 accepted at E0.
//     -> o_alu_*={01,0011,0101} after E0; o_rsp_valid after E2; result=4'b0001, status=4'b0000.
//  T2 CONV: op=11, A=4'b1101 -> result=4'b1011 (sign-magnitude -3), status=0, op=11.
//  T3 Unsupported: op=00, A=5, B=1 -> rsp valid after E0 with result=0, status=4'b1000.
//     o_alu_* unchanged, o_err_count=1.
//  T4 Backpressure: hold i_rsp_ready=0 for 5 clocks after rsp_valid.
//     -> o_rsp_* stable, o_cmd_ready=0. Raise ready with the next cmd valid -> both handshakes on one edge.
//  T5 Reset mid-WAIT: assert i_reset=0 between E0 and E2.
//     -> all outputs 0 immediately, no response after release, o_cmd_ready=1 one edge after release.
//  T6 Saturation: 260 back-to-back op=10 commands -> o_err_count=255 and holds; each gives status 4'b1000.

Source files
------------

// File: rtl/alu_op_issuer_if.sv
// rtl/alu_op_issuer_if.sv - command, ALU-drive and response signals between issuer and its environment
interface alu_op_issuer_if #(
    parameter int N = 2,
    parameter int M = 4
);
    logic         cmd_valid;
    logic         cmd_ready;
    logic [N-1:0] cmd_op;
    logic [M-1:0] cmd_a;
    logic [M-1:0] cmd_b;
    logic [N-1:0] alu_op;
    logic [M-1:0] alu_a;
    logic [M-1:0] alu_b;
    logic [M-1:0] alu_result;
    logic [3:0]   alu_status;
    logic         rsp_valid;
    logic         rsp_ready;
    logic [N-1:0] rsp_op;
    logic [M-1:0] rsp_result;
    logic [3:0]   rsp_status;
    logic [7:0]   err_count;

    modport master (
        input  cmd_valid, cmd_op, cmd_a, cmd_b, alu_result, alu_status, rsp_ready,
        output cmd_ready, alu_op, alu_a, alu_b, rsp_valid, rsp_op, rsp_result, rsp_status, err_count
    );

    modport slave (
        output cmd_valid, cmd_op, cmd_a, cmd_b, alu_result, alu_status, rsp_ready,
        input  cmd_ready, alu_op, alu_a, alu_b, rsp_valid, rsp_op, rsp_result, rsp_status, err_count
    );
endinterface

// File: rtl/alu_op_issuer.sv
// rtl/alu_op_issuer.sv - issues (op, A, B) commands to a fixed-latency ALU and returns its result
module alu_op_issuer #(
    parameter int               N       = 2,
    parameter int               M       = 4,
    parameter int               LAT     = 1,
    parameter logic [2**N-1:0]  OP_MASK = 4'b1010
) (
    input  logic             i_clk,
    input  logic             i_reset,
    alu_op_issuer_if.master  bus
);
    localparam int CW = $clog2(LAT + 1);

    typedef enum logic [1:0] {IDLE, WAIT, HOLD} state_t;

    state_t        state;
    logic          started;
    logic [CW-1:0] cnt;
    logic          cmd_fire;
    logic          op_ok;
    logic          unused_status_msb;

    // ready stays low until the first edge after reset release
    assign bus.cmd_ready     = started & ((state == IDLE) | ((state == HOLD) & bus.rsp_ready));
    assign cmd_fire          = bus.cmd_valid & bus.cmd_ready;
    assign op_ok             = OP_MASK[bus.cmd_op];
    assign unused_status_msb = bus.alu_status[3];

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state          <= IDLE;
            started        <= 1'b0;
            cnt            <= '0;
            bus.alu_op     <= '0;
            bus.alu_a      <= '0;
            bus.alu_b      <= '0;
            bus.rsp_valid  <= 1'b0;
            bus.rsp_op     <= '0;
            bus.rsp_result <= '0;
            bus.rsp_status <= '0;
            bus.err_count  <= '0;
        end else begin
            started <= 1'b1;
            if (cmd_fire) begin
                if (op_ok) begin
                    bus.alu_op    <= bus.cmd_op;
                    bus.alu_a     <= bus.cmd_a;
                    bus.alu_b     <= bus.cmd_b;
                    cnt           <= CW'(LAT);
                    bus.rsp_valid <= 1'b0;
                    state         <= WAIT;
                end else begin
                    // rejected ops never reach the ALU; answer on the very next cycle
                    bus.rsp_valid  <= 1'b1;
                    bus.rsp_op     <= bus.cmd_op;
                    bus.rsp_result <= '0;
                    bus.rsp_status <= 4'b1000;
                    if (bus.err_count != 8'hFF)
                        bus.err_count <= bus.err_count + 8'd1;
                    state <= HOLD;
                end
            end else begin
                case (state)
                    WAIT: begin
                        if (cnt == '0) begin
                            // alu_op is still the issued opcode, it only changes on accept
                            bus.rsp_valid  <= 1'b1;
                            bus.rsp_op     <= bus.alu_op;
                            bus.rsp_result <= bus.alu_result;
                            bus.rsp_status <= {1'b0, bus.alu_status[2:0]};
                            state          <= HOLD;
                        end else begin
                            cnt <= cnt - 1'b1;
                        end
                    end
                    HOLD: begin
                        if (bus.rsp_ready) begin
                            bus.rsp_valid <= 1'b0;
                            state         <= IDLE;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_alu_op_issuer.sv
// tb/tb_alu_op_issuer.sv - scoreboard bench for alu_op_issuer with a latency-1 ALU model
module tb_alu_op_issuer;
    logic i_clk;
    logic i_reset;

    alu_op_issuer_if #(.N(2), .M(4)) bus ();

    alu_op_issuer #(.N(2), .M(4), .LAT(1), .OP_MASK(4'b1010)) dut (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .bus     (bus.master)
    );

    typedef struct {
        logic [1:0] op;
        logic [3:0] res;
        logic [3:0] st;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    // COMP: A<B flag, CONV: two's complement to sign-magnitude, others: xor
    function automatic logic [3:0] alu_f(input logic [1:0] op, input logic [3:0] a, input logic [3:0] b);
        logic [3:0] n;
        n = 4'd0 - a;
        case (op)
            2'b01:   alu_f = {3'b000, (a < b)};
            2'b11:   alu_f = a[3] ? {1'b1, n[2:0]} : a;
            default: alu_f = a ^ b;
        endcase
    endfunction

    // status[3] is always set by the model; the issuer must not forward it
    always @(posedge i_clk) begin
        bus.alu_result <= alu_f(bus.alu_op, bus.alu_a, bus.alu_b);
        bus.alu_status <= {1'b1, 2'b00, (alu_f(bus.alu_op, bus.alu_a, bus.alu_b) == 4'd0)};
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic flag_fail(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s", name);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_cmd_ready"}, 32'(bus.cmd_ready), 0);
        check({tag, "_alu"}, {22'd0, bus.alu_op, bus.alu_a, bus.alu_b}, 0);
        check({tag, "_rsp_valid"}, 32'(bus.rsp_valid), 0);
        check({tag, "_rsp"}, {22'd0, bus.rsp_op, bus.rsp_result, bus.rsp_status}, 0);
        check({tag, "_err_count"}, 32'(bus.err_count), 0);
    endtask

    // drive one command until accepted; the expectation is queued at the accepting edge
    task automatic send(input logic [1:0] op, input logic [3:0] a, input logic [3:0] b,
                        input logic [3:0] er, input logic [3:0] es, input bit expect_rsp);
        int t;
        bit ok;
        exp_t e;
        t  = 0;
        ok = 1'b0;
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = op;
        bus.cmd_a     = a;
        bus.cmd_b     = b;
        while (!ok && t < 50) begin
            @(negedge i_clk);
            if (bus.cmd_ready) ok = 1'b1;
            else begin
                t++;
                @(posedge i_clk);
            end
        end
        if (!ok) flag_fail("cmd_accept_timeout");
        else if (expect_rsp) begin
            e.op = op; e.res = er; e.st = es;
            sb.push_back(e);
        end
        @(posedge i_clk);
        #1;
        bus.cmd_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int t;
        t = 0;
        while ((sb.size() != 0 || bus.rsp_valid) && t < 100) begin
            @(posedge i_clk);
            #1;
            t++;
        end
        if (t >= 100) flag_fail("drain_timeout");
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge i_clk);
            if (i_reset && bus.rsp_valid && bus.rsp_ready) begin
                if (sb.size() == 0) flag_fail("rsp_unexpected");
                else begin
                    e = sb.pop_front();
                    check("rsp_op", 32'(bus.rsp_op), 32'(e.op));
                    check("rsp_result", 32'(bus.rsp_result), 32'(e.res));
                    check("rsp_status", 32'(bus.rsp_status), 32'(e.st));
                end
            end
        end
    end

    initial begin : stim
        logic [1:0] h_op;
        logic [3:0] h_res, h_st;
        int t;

        i_reset       = 1'b0;
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = '0;
        bus.cmd_a     = '0;
        bus.cmd_b     = '0;
        bus.rsp_ready = 1'b1;
        #23;
        check_all_zero("reset");
        @(negedge i_clk);
        #1;
        i_reset = 1'b1;
        check("ready_before_edge", 32'(bus.cmd_ready), 0);
        @(posedge i_clk);
        #1;
        check("ready_after_release", 32'(bus.cmd_ready), 1);

        // T1 COMP with exact latency
        send(2'b01, 4'b0011, 4'b0101, 4'b0001, 4'b0000, 1'b1);
        check("t1_alu_drive", {26'd0, bus.alu_op, bus.alu_a, bus.alu_b}, {26'd0, 2'b01, 4'b0011, 4'b0101});
        check("t1_valid_e0", 32'(bus.rsp_valid), 0);
        @(posedge i_clk); #1;
        check("t1_valid_e1", 32'(bus.rsp_valid), 0);
        @(posedge i_clk); #1;
        check("t1_valid_e2", 32'(bus.rsp_valid), 1);

        // T2 CONV negative, then T3 unsupported right behind it
        send(2'b11, 4'b1101, 4'b0000, 4'b1011, 4'b0000, 1'b1);
        send(2'b00, 4'b0101, 4'b0001, 4'b0000, 4'b1000, 1'b1);
        check("t3_alu_unchanged", {26'd0, bus.alu_op, bus.alu_a, bus.alu_b}, {26'd0, 2'b11, 4'b1101, 4'b0000});
        check("t3_err_count", 32'(bus.err_count), 1);
        check("t3_valid_e0", 32'(bus.rsp_valid), 1);
        wait_idle();

        // T4 backpressure; zero result exercises status[2:0] passthrough
        bus.rsp_ready = 1'b0;
        send(2'b01, 4'b0111, 4'b0010, 4'b0000, 4'b0001, 1'b1);
        t = 0;
        while (!bus.rsp_valid && t < 20) begin
            @(posedge i_clk); #1; t++;
        end
        if (t >= 20) flag_fail("t4_rsp_timeout");
        h_op = bus.rsp_op; h_res = bus.rsp_result; h_st = bus.rsp_status;
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = 2'b11;
        bus.cmd_a     = 4'b0101;
        bus.cmd_b     = 4'b0000;
        for (int i = 0; i < 5; i++) begin
            @(posedge i_clk); #1;
            check("t4_hold_stable", {20'd0, bus.rsp_valid, bus.rsp_op, bus.rsp_result, bus.rsp_status},
                  {20'd0, 1'b1, h_op, h_res, h_st});
            check("t4_cmd_ready_low", 32'(bus.cmd_ready), 0);
        end
        bus.rsp_ready = 1'b1;
        send(2'b11, 4'b0101, 4'b0000, 4'b0101, 4'b0000, 1'b1);
        check("t4_dual_handshake", {30'd0, bus.rsp_valid, bus.cmd_ready}, 0);
        wait_idle();

        // T5 reset between E0 and E2
        send(2'b01, 4'b0001, 4'b0010, 4'b0000, 4'b0000, 1'b0);
        i_reset = 1'b0;
        #1;
        check_all_zero("t5_reset");
        @(posedge i_clk);
        @(negedge i_clk); #1;
        i_reset = 1'b1;
        check("t5_ready_before_edge", 32'(bus.cmd_ready), 0);
        @(posedge i_clk); #1;
        check("t5_ready_after_edge", 32'(bus.cmd_ready), 1);
        for (int i = 0; i < 6; i++) begin
            @(posedge i_clk); #1;
            check("t5_no_rsp", 32'(bus.rsp_valid), 0);
        end

        // T6 error counter saturation with back-to-back rejects
        for (int i = 0; i < 260; i++) begin
            send(2'b10, 4'(i), 4'b0000, 4'b0000, 4'b1000, 1'b1);
            if (i == 253) check("t6_err_254", 32'(bus.err_count), 254);
        end
        @(posedge i_clk); #1;
        check("t6_err_saturated", 32'(bus.err_count), 255);
        wait_idle();
        check("t6_err_holds", 32'(bus.err_count), 255);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
